// File: rtl/coef_loader.sv
// ---------------------------------------------------------------------------
// coef_loader : writer side of the lowpass coefficient RAM.
//
// Parses a framed byte stream and turns each data byte into one RAM write.
//    frame = SYNC_BYTE, START (bit7 ignored), LEN (0 = 128), LEN data bytes
//            [, CSUM when COEF_LOADER_CHECKSUM_EN is defined]
//
// Build option:
//    COEF_LOADER_CHECKSUM_EN  defined -> a trailing CSUM byte is required and
//                             compared with the 8-bit sum of the data bytes.
//                             undefined -> frame ends on the last data byte and
//                             the sum logic is not built.
//
// Ports:
//    clock      master clock
//    reset      asynchronous, active-low reset
//    rx_data    received byte, qualified by rx_valid
//    rx_valid   one-cycle strobe per byte (may be back-to-back)
//    ram_we     RAM write enable, one cycle per coefficient
//    ram_addr   RAM write address (holds when ram_we=0)
//    ram_wdata  RAM write data (holds when ram_we=0)
//    busy       frame in progress
//    coefs_ok   last load succeeded; cleared by a new header
//    load_done  one-cycle pulse on a good frame
//    load_err   one-cycle pulse on checksum mismatch or inter-byte timeout
// All outputs are registered; a byte shows up on ram_we one cycle after it
// is strobed in.
// ---------------------------------------------------------------------------
module coef_loader #(
   parameter int         ADDR_W    = 7,
   parameter int         DATA_W    = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 50000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              busy,
   output logic              coefs_ok,
   output logic              load_done,
   output logic              load_err
);

   localparam int CNT_W = ADDR_W + 1;               // must hold 2**ADDR_W
   localparam int GAP_W = $clog2(TIMEOUT + 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic                busy_q, busy_d;
   logic                coefs_ok_q, coefs_ok_d;
   logic                load_done_q, load_done_d;
   logic                load_err_q, load_err_d;
`ifdef COEF_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0]   sum_q, sum_d;
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      coefs_ok_d  = coefs_ok_q;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
`ifdef COEF_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif

      // Inter-byte watchdog; only the no-byte path can time out, so it never
      // competes with the per-state byte handling below.
      if (state_q != IDLE) begin
         if (rx_valid) begin
            gap_d = '0;
         end else if (gap_q == GAP_LIMIT) begin
            gap_d      = '0;
            state_d    = IDLE;
            load_err_d = 1'b1;
         end else begin
            gap_d = gap_q + GAP_W'(1);
         end
      end

      case (state_q)
         IDLE: begin
            // A byte arriving while the done/err pulse is out is dropped.
            if (rx_valid && !(load_done_q || load_err_q) && rx_data == SYNC_BYTE) begin
               state_d    = ADDR;
               coefs_ok_d = 1'b0;
               gap_d      = '0;
            end
         end
         ADDR: if (rx_valid) begin
            ptr_d   = rx_data[ADDR_W-1:0];
            state_d = LEN;
         end
         LEN: if (rx_valid) begin
            cnt_d   = (rx_data == 8'd0) ? CNT_W'(2 ** ADDR_W) : CNT_W'(rx_data);
`ifdef COEF_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = DATA;
         end
         DATA: if (rx_valid) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = ptr_q;
            ram_wdata_d = rx_data[DATA_W-1:0];
            ptr_d       = ptr_q + ADDR_W'(1);       // wraps modulo RAM depth
            cnt_d       = cnt_q - CNT_W'(1);
`ifdef COEF_LOADER_CHECKSUM_EN
            sum_d       = sum_q + rx_data[DATA_W-1:0];
            if (cnt_q == CNT_W'(1)) state_d = CSUM;
`else
            if (cnt_q == CNT_W'(1)) begin
               state_d     = IDLE;
               load_done_d = 1'b1;
               coefs_ok_d  = 1'b1;
            end
`endif
         end
`ifdef COEF_LOADER_CHECKSUM_EN
         CSUM: if (rx_valid) begin
            state_d = IDLE;
            if (rx_data[DATA_W-1:0] == sum_q) begin
               load_done_d = 1'b1;
               coefs_ok_d  = 1'b1;
            end else begin
               load_err_d  = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         busy_q      <= 1'b0;
         coefs_ok_q  <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
`ifdef COEF_LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         busy_q      <= busy_d;
         coefs_ok_q  <= coefs_ok_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
`ifdef COEF_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign busy      = busy_q;
   assign coefs_ok  = coefs_ok_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule
